// File: rtl/tdm_mux_ctrl.sv
// tdm_mux_ctrl: select controller for the TDM bypass mux.
// Switches the mux between the register path (0) and the bypass path (1)
// only after the current source completes a frame. It then masks valid for
// a guard interval, forces the switch after a drain timeout, and keeps
// diagnostic status.
module tdm_mux_ctrl #(
  parameter int unsigned GUARD   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bypassReq,
  input  logic             tdmPdataValid0,
  input  logic             tdmPdataValid1,
  input  logic             errClr,
  output logic             sel,
  output logic             validEn,
  output logic             switching,
  output logic             timeoutErr,
  output logic [CNT_W-1:0] switchCnt
);

  localparam int unsigned DrainW = $clog2(TIMEOUT);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(TIMEOUT - 1);
  localparam logic [7:0] GuardLoad = 8'(GUARD - 1);

  typedef enum logic [1:0] {StRun, StDrain, StGuard} state_e;

  state_e            state_q;
  logic [DrainW-1:0] drain_cnt_q;
  logic [7:0]        guard_cnt_q;
  logic              sel_q;
  logic              valid_en_q;
  logic              switching_q;
  logic              timeout_err_q;
  logic [CNT_W-1:0]  switch_cnt_q;

  logic cur_valid;
  logic req_diff;
  logic drain_last;
  logic do_switch;
  logic force_set;

  // Switch decisions; the non-selected strobe never reaches cur_valid.
  always_comb begin
    cur_valid  = sel_q ? tdmPdataValid1 : tdmPdataValid0;
    req_diff   = (bypassReq != sel_q);
    drain_last = (drain_cnt_q == DrainLast);
    do_switch  = (state_q == StDrain) && req_diff && (cur_valid || drain_last);
    // A frame strobe on the timeout cycle counts as a normal switch.
    force_set  = (state_q == StDrain) && req_diff && !cur_valid && drain_last;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      drain_cnt_q   <= '0;
      guard_cnt_q   <= '0;
      sel_q         <= 1'b0;
      valid_en_q    <= 1'b1;
      switching_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      switch_cnt_q  <= '0;
    end else begin
      // Setting the sticky error wins over a same-cycle clear.
      if (force_set) begin
        timeout_err_q <= 1'b1;
      end else if (errClr) begin
        timeout_err_q <= 1'b0;
      end

      unique case (state_q)
        StRun: begin
          if (req_diff) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
            switching_q <= 1'b1;
          end
        end
        StDrain: begin
          drain_cnt_q <= drain_cnt_q + DrainW'(1);
          if (!req_diff) begin
            state_q     <= StRun;
            switching_q <= 1'b0;
          end else if (do_switch) begin
            sel_q        <= ~sel_q;
            switch_cnt_q <= switch_cnt_q + CNT_W'(1);
            guard_cnt_q  <= GuardLoad;
            valid_en_q   <= 1'b0;
            state_q      <= StGuard;
          end
        end
        StGuard: begin
          if (guard_cnt_q == 8'd0) begin
            state_q     <= StRun;
            valid_en_q  <= 1'b1;
            switching_q <= 1'b0;
          end else begin
            guard_cnt_q <= guard_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign validEn    = valid_en_q;
  assign switching  = switching_q;
  assign timeoutErr = timeout_err_q;
  assign switchCnt  = switch_cnt_q;

endmodule
